// File: rtl/rotate_tracker.sv
// rtl/rotate_tracker.sv - tracks net rotation of a rotating register and returns the de-rotated byte
module rotate_tracker #(
  parameter int WIDTH = 8,
  localparam int OFFW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             load,
  input  logic             rot_en,
  input  logic             r_l,
  input  logic             rd_req,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [OFFW-1:0]  offset,
  output logic             out_valid,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [OFFW-1:0] OFF_MAX = OFFW'(WIDTH - 1);

  state_t           state;
  logic [OFFW-1:0]  off_next;
  logic [OFFW-1:0]  cap_off;
  logic [WIDTH-1:0] derot;

  // Next offset: load clears, rotations step with explicit wrap so non-power-of-2 widths stay in range
  always_comb begin
    off_next = offset;
    if (load) begin
      off_next = '0;
    end else if (rot_en) begin
      if (r_l) begin
        off_next = (offset == OFF_MAX) ? '0 : offset + 1'b1;
      end else begin
        off_next = (offset == '0) ? OFF_MAX : offset - 1'b1;
      end
    end
  end

  // De-rotation: a load in the capture cycle means q_in is unrotated, so use offset 0
  always_comb begin
    cap_off = load ? '0 : offset;
    derot   = (q_in >> cap_off) | (q_in << (WIDTH - int'(cap_off)));
  end

  // Control FSM with registered outputs; offset only tracks once valid data has been loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      offset    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          offset <= '0;
          if (load) begin
            state <= TRACK;
            if (rd_req) begin
              data_out  <= q_in;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end else if (rd_req) begin
            err <= 1'b1;
          end
        end
        TRACK: begin
          offset <= off_next;
          if (rd_req) begin
            data_out  <= derot;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          offset <= off_next;
          if (rd_req) begin
            err <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= TRACK;
          end
        end
        default: begin
          state     <= IDLE;
          offset    <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_tracker.sv
// tb/tb_rotate_tracker.sv - table-driven scoreboard bench for rotate_tracker
module tb_rotate_tracker;

  logic       clk;
  logic       rst;
  logic [7:0] q_in;
  logic       load;
  logic       rot_en;
  logic       r_l;
  logic       rd_req;
  logic       out_ready;
  logic [7:0] data_out;
  logic [2:0] offset;
  logic       out_valid;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    bit       ld;
    bit       rot;
    bit       rl;
    bit       rd;
    bit       rdy;
    bit [7:0] q;
    bit [2:0] e_off;
    bit       e_val;
    bit       e_err;
    bit       push;
    bit [7:0] pdata;
  } vec_t;

  vec_t vecs[$];

  rotate_tracker #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .load      (load),
    .rot_en    (rot_en),
    .r_l       (r_l),
    .rd_req    (rd_req),
    .out_ready (out_ready),
    .data_out  (data_out),
    .offset    (offset),
    .out_valid (out_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit ld, bit rot, bit rl, bit rd, bit rdy, bit [7:0] q,
                              bit [2:0] e_off, bit e_val, bit e_err, bit push, bit [7:0] pdata);
    vec_t v;
    v.ld = ld; v.rot = rot; v.rl = rl; v.rd = rd; v.rdy = rdy; v.q = q;
    v.e_off = e_off; v.e_val = e_val; v.e_err = e_err; v.push = push; v.pdata = pdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic       hs;
    logic [7:0] pre_data;
    logic [7:0] exp_d;
    @(negedge clk);
    load = v.ld; rot_en = v.rot; r_l = v.rl; rd_req = v.rd; out_ready = v.rdy; q_in = v.q;
    if (v.push) sb.push_back(v.pdata);
    hs = out_valid && out_ready;
    pre_data = data_out;
    @(posedge clk);
    #1;
    if (hs) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s handshake: data 0x%0h accepted with no expected entry", tag, pre_data);
      end else begin
        exp_d = sb.pop_front();
        chk({tag, " accepted_data"}, 32'(pre_data), 32'(exp_d));
      end
    end
    chk({tag, " offset"}, 32'(offset), 32'(v.e_off));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_val));
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s held_data: out_valid with data 0x%0h but nothing expected", tag, data_out);
      end else begin
        chk({tag, " held_data"}, 32'(data_out), 32'(sb[0]));
      end
    end
  endtask

  initial begin
    rst = 1'b0; q_in = '0; load = 0; rot_en = 0; r_l = 0; rd_req = 0; out_ready = 0;

    //          ld rot rl rd rdy q      off val err push pdata
    vecs.push_back(mk(0,0,0,1,0, 8'h00, 0,0,1, 0,8'h00)); // idle rd_req -> err
    vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h00, 0,0,0, 0,8'h00)); // idle ignores rotation
    vecs.push_back(mk(1,0,0,0,0, 8'hB4, 0,0,0, 0,8'h00)); // load
    vecs.push_back(mk(0,1,1,0,0, 8'hB4, 1,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h69, 2,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'hD2, 3,0,0, 0,8'h00));
    vecs.push_back(mk(0,0,0,1,0, 8'hA5, 3,1,0, 1,8'hB4)); // capture offset 3
    vecs.push_back(mk(0,0,0,0,0, 8'hA5, 3,1,0, 0,8'h00)); // held
    vecs.push_back(mk(0,0,0,0,1, 8'hA5, 3,0,0, 0,8'h00)); // accepted
    vecs.push_back(mk(1,0,0,0,0, 8'hB4, 0,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,0,0,0, 8'hB4, 7,0,0, 0,8'h00)); // right wrap 0 -> 7
    vecs.push_back(mk(0,0,0,1,0, 8'h5A, 7,1,0, 1,8'hB4));
    vecs.push_back(mk(0,0,0,0,1, 8'h5A, 7,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h5A, 0,0,0, 0,8'h00)); // left wrap 7 -> 0
    vecs.push_back(mk(0,1,1,0,0, 8'hB4, 1,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h69, 2,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'hD2, 3,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'hA5, 4,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h4B, 5,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h96, 6,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h2D, 7,0,0, 0,8'h00));
    vecs.push_back(mk(0,0,0,1,0, 8'h5A, 7,1,0, 1,8'hB4)); // capture after 8 lefts
    vecs.push_back(mk(0,1,1,1,0, 8'h5A, 0,1,1, 0,8'h00)); // rd in OUT -> err, offset tracks
    vecs.push_back(mk(0,1,1,1,0, 8'hB4, 1,1,1, 0,8'h00));
    vecs.push_back(mk(0,1,1,1,0, 8'h69, 2,1,1, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'hD2, 3,1,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,1,0, 8'hA5, 4,1,1, 0,8'h00));
    vecs.push_back(mk(0,0,0,0,1, 8'h4B, 4,0,0, 0,8'h00));
    vecs.push_back(mk(1,0,0,1,0, 8'h3C, 0,1,0, 1,8'h3C)); // load + rd_req
    vecs.push_back(mk(0,0,0,0,1, 8'h3C, 0,0,0, 0,8'h00));
    vecs.push_back(mk(1,1,1,1,0, 8'h3C, 0,1,0, 1,8'h3C)); // load + rot_en + rd_req
    vecs.push_back(mk(0,0,0,0,1, 8'h3C, 0,0,0, 0,8'h00));
    vecs.push_back(mk(0,1,1,0,0, 8'h3C, 1,0,0, 0,8'h00));
    vecs.push_back(mk(0,0,0,1,0, 8'h78, 1,1,0, 1,8'h3C));
    vecs.push_back(mk(1,0,0,0,0, 8'h11, 0,1,0, 0,8'h00)); // load in OUT keeps held data
    vecs.push_back(mk(0,0,0,0,1, 8'h11, 0,0,0, 0,8'h00));
    vecs.push_back(mk(0,0,0,0,1, 8'h11, 0,0,0, 0,8'h00)); // out_ready while idle output

    #12;
    chk("reset offset", 32'(offset), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    #10 rst = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of an output handshake
    step(mk(1,0,0,0,0, 8'hB4, 0,0,0, 0,8'h00), "ar_load");
    step(mk(0,1,1,0,0, 8'hB4, 1,0,0, 0,8'h00), "ar_rot");
    step(mk(0,0,0,1,0, 8'h69, 1,1,0, 1,8'hB4), "ar_cap");
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async data_out", 32'(data_out), 32'd0);
    chk("async offset", 32'(offset), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    step(mk(0,0,0,1,0, 8'h00, 0,0,1, 0,8'h00), "post_rst_rd");
    step(mk(0,1,1,0,0, 8'h00, 0,0,0, 0,8'h00), "post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
